// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
// Module   : song_reader
// Purpose  : Walks a {note, duration} song ROM and feeds a note_player one
//            note at a time, reporting the end of the song.
// Revision : 1.0
// ============================================================================
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [11:0]                    rom_data,
  output logic [5:0]                     note_to_load,
  output logic [5:0]                     duration_to_load,
  output logic                           load_new_note,
  input  logic                           done_with_note,
  output logic                           song_done
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_fetch  = 3'd1;
  localparam logic [2:0] c_decode = 3'd2;
  localparam logic [2:0] c_arm    = 3'd3;
  localparam logic [2:0] c_wait   = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [NOTE_BITS-1:0] r_note_idx;
  logic [NOTE_BITS-1:0] w_note_idx_next;
  logic [SONG_BITS-1:0] r_song_q;
  logic [SONG_BITS-1:0] w_song_q_next;
  logic                 r_finished;
  logic                 w_finished_next;
  logic                 w_load_next;
  logic                 w_song_done_next;
  logic                 w_capture;
  logic                 w_abort;
  logic                 w_end_marker;
  logic                 w_idx_max;

  // A song change outside IDLE abandons the current song at once.
  assign w_abort      = (r_state != c_idle) && (song != r_song_q);
  assign w_end_marker = (rom_data[5:0] == 6'd0);
  assign w_idx_max    = (r_note_idx == {NOTE_BITS{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:   if (play && !r_finished) w_state_next = c_fetch;
      c_fetch:  if (play) w_state_next = c_decode;
      c_decode: if (play) w_state_next = w_end_marker ? c_idle : c_arm;
      c_arm:    w_state_next = c_wait;
      c_wait:   if (play && done_with_note) w_state_next = w_idx_max ? c_idle : c_fetch;
      default:  w_state_next = c_idle;
    endcase
    if (w_abort) w_state_next = c_idle;
  end

  always_comb begin
    w_note_idx_next  = r_note_idx;
    w_song_q_next    = r_song_q;
    w_finished_next  = r_finished;
    w_load_next      = 1'b0;
    w_song_done_next = 1'b0;
    w_capture        = 1'b0;
    // Dropping play re-arms a finished song for another run.
    if (!play) w_finished_next = 1'b0;
    if (w_abort) begin
      w_note_idx_next = '0;
      w_finished_next = 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (play && !r_finished) begin
            w_song_q_next   = song;
            w_note_idx_next = '0;
          end
        end
        c_decode: begin
          if (play) begin
            if (w_end_marker) begin
              w_song_done_next = 1'b1;
              w_note_idx_next  = '0;
              w_finished_next  = 1'b1;
            end else begin
              w_capture   = 1'b1;
              w_load_next = 1'b1;
            end
          end
        end
        c_wait: begin
          if (play && done_with_note) begin
            if (w_idx_max) begin
              w_song_done_next = 1'b1;
              w_note_idx_next  = '0;
              w_finished_next  = 1'b1;
            end else begin
              w_note_idx_next = r_note_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_note_idx       <= '0;
      r_song_q         <= song;
      r_finished       <= 1'b0;
      rom_addr         <= '0;
      note_to_load     <= 6'd0;
      duration_to_load <= 6'd0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      r_note_idx    <= w_note_idx_next;
      r_song_q      <= w_song_q_next;
      r_finished    <= w_finished_next;
      rom_addr      <= {w_song_q_next, w_note_idx_next};
      load_new_note <= w_load_next;
      song_done     <= w_song_done_next;
      if (w_capture) begin
        note_to_load     <= rom_data[11:6];
        duration_to_load <= rom_data[5:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_song_reader.sv
`default_nettype none
// Bench for song_reader: per-cycle vector table, directed corner sequences,
// and random songs checked against an expected note list.
module tb_song_reader;
  localparam int SB = 2;
  localparam int NB = 5;

  typedef struct {
    logic       play;
    logic       done;
    logic       exp_load;
    logic       exp_sd;
    logic [5:0] exp_note;
    logic [5:0] exp_dur;
    logic [6:0] exp_addr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play = 1'b0;
  logic          done_with_note = 1'b0;
  logic [SB-1:0] song = '0;
  logic [SB+NB-1:0] rom_addr;
  logic [11:0]   rom_data = '0;
  logic [5:0]    note_to_load;
  logic [5:0]    duration_to_load;
  logic          load_new_note;
  logic          song_done;
  logic [11:0]   rom [0:127];
  int            checks = 0;
  int            errors = 0;
  int            sd_count = 0;

  song_reader #(.SONG_BITS(SB), .NOTE_BITS(NB)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .done_with_note   (done_with_note),
    .song_done        (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (song_done) begin
      sd_count++;
      check("sd_load_exclusive", {31'd0, load_new_note}, 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_load(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!load_new_note && n < budget);
    if (!load_new_note) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: no load within %0d cycles", budget);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!song_done && n < budget);
    if (!song_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no song_done within %0d cycles", budget);
    end
  endtask

  function automatic vec_t mkv(input logic p, input logic d, input logic l, input logic s,
                               input int n, input int du, input int a);
    vec_t r;
    r.play = p; r.done = d; r.exp_load = l; r.exp_sd = s;
    r.exp_note = 6'(n); r.exp_dur = 6'(du); r.exp_addr = 7'(a);
    return r;
  endfunction

  function automatic logic [11:0] nd(input int n, input int d);
    return {6'(n), 6'(d)};
  endfunction

  function automatic logic [18:0] payload();
    return {rom_addr, note_to_load, duration_to_load};
  endfunction

  function automatic logic [18:0] exp_payload(input int s, input int i);
    logic [11:0] w;
    w = rom[s*32+i];
    return {7'(s*32+i), w};
  endfunction

  vec_t vecs [15];

  initial begin
    int n;
    int cnt;
    int sd0;
    logic [18:0] held;
    logic [18:0] q [$];

    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    rom[0] = nd(10, 4); rom[1] = nd(12, 2); rom[2] = nd(0, 0);
    rom[32] = nd(20, 3); rom[33] = nd(21, 5); rom[34] = nd(22, 1); rom[35] = nd(0, 0);
    rom[64] = nd(40, 7); rom[65] = nd(0, 0);
    for (int i = 0; i < 32; i++) rom[96+i] = nd((i*5+3) % 64, (i % 7) + 1);

    vecs[0]  = mkv(1, 0, 0, 0,  0, 0, 0);
    vecs[1]  = mkv(1, 0, 0, 0,  0, 0, 0);
    vecs[2]  = mkv(1, 0, 1, 0, 10, 4, 0);
    vecs[3]  = mkv(1, 1, 0, 0, 10, 4, 0);
    vecs[4]  = mkv(1, 0, 0, 0, 10, 4, 0);
    vecs[5]  = mkv(1, 1, 0, 0, 10, 4, 1);
    vecs[6]  = mkv(1, 0, 0, 0, 10, 4, 1);
    vecs[7]  = mkv(1, 0, 1, 0, 12, 2, 1);
    vecs[8]  = mkv(1, 1, 0, 0, 12, 2, 1);
    vecs[9]  = mkv(1, 1, 0, 0, 12, 2, 2);
    vecs[10] = mkv(1, 0, 0, 0, 12, 2, 2);
    vecs[11] = mkv(1, 0, 0, 1, 12, 2, 0);
    vecs[12] = mkv(1, 0, 0, 0, 12, 2, 0);
    vecs[13] = mkv(1, 1, 0, 0, 12, 2, 0);
    vecs[14] = mkv(1, 1, 0, 0, 12, 2, 0);

    // Reset state
    repeat (2) step();
    check("reset_outputs", {13'd0, rom_addr, note_to_load, duration_to_load, load_new_note, song_done}, 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Song 0 cycle by cycle
    for (int i = 0; i < 15; i++) begin
      play = vecs[i].play;
      done_with_note = vecs[i].done;
      step();
      check($sformatf("vec%0d", i),
            {11'd0, load_new_note, song_done, note_to_load, duration_to_load, rom_addr},
            {11'd0, vecs[i].exp_load, vecs[i].exp_sd, vecs[i].exp_note, vecs[i].exp_dur, vecs[i].exp_addr});
    end

    // 32-note song with done held high: one load every 4 cycles, then wrap
    play = 1'b0; done_with_note = 1'b0; step();
    song = 2'd3; play = 1'b1; done_with_note = 1'b1;
    wait_load(10, n);
    check("s3_first_latency", n, 3);
    check("s3_load0", payload(), exp_payload(3, 0));
    for (int i = 1; i < 32; i++) begin
      wait_load(10, n);
      check($sformatf("s3_gap%0d", i), n, 4);
      check($sformatf("s3_load%0d", i), payload(), exp_payload(3, i));
    end
    wait_done(10, n);
    check("s3_done_latency", n, 2);
    check("s3_addr_wrap", rom_addr, 7'd96);
    cnt = 0;
    repeat (6) begin step(); if (load_new_note) cnt++; end
    check("s3_no_reload", cnt, 0);

    // Pause in WAIT with done asserted
    play = 1'b0; done_with_note = 1'b0; step();
    song = 2'd1; play = 1'b1;
    wait_load(10, n);
    check("s1_load0", payload(), exp_payload(1, 0));
    step();
    held = payload();
    play = 1'b0; done_with_note = 1'b1;
    cnt = 0;
    repeat (20) begin
      step();
      if (load_new_note || payload() != held) cnt++;
    end
    check("pause_frozen", cnt, 0);
    play = 1'b1;
    wait_load(10, n);
    check("pause_resume_latency", n, 3);
    check("s1_load1", payload(), exp_payload(1, 1));

    // Song change 1 -> 2 while waiting
    done_with_note = 1'b0;
    step();
    sd0 = sd_count;
    song = 2'd2;
    wait_load(10, n);
    check("abort_restart_latency", n, 4);
    check("s2_load0", payload(), exp_payload(2, 0));
    check("abort_no_song_done", sd_count, sd0);
    done_with_note = 1'b1;
    wait_done(10, n);

    // Reset during ARM
    play = 1'b0; done_with_note = 1'b0; step();
    song = 2'd0; play = 1'b1;
    wait_load(10, n);
    check("arm_before_reset", {31'd0, load_new_note}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {13'd0, rom_addr, note_to_load, duration_to_load, load_new_note, song_done}, 32'd0);
    step();
    check("held_reset_outputs", {13'd0, rom_addr, note_to_load, duration_to_load, load_new_note, song_done}, 32'd0);
    reset = 1'b0;
    wait_load(10, n);
    check("post_reset_latency", n, 3);
    check("post_reset_load0", payload(), exp_payload(0, 0));

    // Random songs against the expected note list
    reset = 1'b1; play = 1'b0; done_with_note = 1'b0;
    step();
    reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      int s;
      int len;
      int cyc;
      s = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 32));
      play = 1'b0;
      song = 2'(s);
      q.delete();
      for (int i = 0; i < 32; i++) begin
        if (i < len) rom[s*32+i] = nd(int'($urandom_range(0, 63)), int'($urandom_range(1, 63)));
        else         rom[s*32+i] = 12'd0;
        if (i < len) q.push_back(exp_payload(s, i));
      end
      repeat (2) step();
      cyc = 0;
      while (!song_done && cyc < 4000) begin
        play = ($urandom_range(0, 9) != 0);
        done_with_note = ($urandom_range(0, 2) == 0);
        step();
        cyc++;
        if (load_new_note) begin
          if (q.size() == 0) check($sformatf("r%0d_extra_load", r), 32'd1, 32'd0);
          else check($sformatf("r%0d_load", r), payload(), q.pop_front());
        end
      end
      if (!song_done) check($sformatf("r%0d_timeout", r), 32'd0, 32'd1);
      check($sformatf("r%0d_all_notes", r), q.size(), 0);
      play = 1'b1;
      cnt = 0;
      repeat (8) begin step(); if (load_new_note) cnt++; end
      check($sformatf("r%0d_stays_idle", r), cnt, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
